// File: rtl/pc_update.sv
// Next-PC selection and PC register for the Y86-64 SEQ processor.
// Picks valP, valC or valM from icode/Cnd and registers it as PC_u for fetch.
module pc_update #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   icode,
  input  logic         Cnd,
  input  logic [W-1:0] valP,
  input  logic [W-1:0] valC,
  input  logic [W-1:0] valM,
  output logic [W-1:0] PC_u
);

  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] ICmov   = 4'h2;
  localparam logic [3:0] IIrmov  = 4'h3;
  localparam logic [3:0] IRmmov  = 4'h4;
  localparam logic [3:0] IMrmov  = 4'h5;
  localparam logic [3:0] IOp     = 4'h6;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPush   = 4'hA;
  localparam logic [3:0] IPop    = 4'hB;

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (icode)
      IJxx:    pc_d = Cnd ? valC : valP;
      ICall:   pc_d = valC;
      IRet:    pc_d = valM;
      INop, ICmov, IIrmov, IRmmov, IMrmov, IOp, IPush, IPop:
               pc_d = valP;
      // halt and the invalid codes 4'hC-4'hF freeze the PC
      IHalt:   pc_d = pc_q;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_u = pc_q;

endmodule

// File: tb/tb_pc_update.sv
// Bench for pc_update: directed vectors with literal expectations plus a
// per-cycle comparison against a rule-level model of the next-PC choice.
module tb_pc_update;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst_n;
  logic [3:0]   icode;
  logic         Cnd;
  logic [W-1:0] valP;
  logic [W-1:0] valC;
  logic [W-1:0] valM;
  logic [W-1:0] PC_u;

  int errors;
  int checks;

  pc_update #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icode (icode),
    .Cnd   (Cnd),
    .valP  (valP),
    .valC  (valC),
    .valM  (valM),
    .PC_u  (PC_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: PC_u=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Rule-level model: which source a given instruction takes the PC from.
  function automatic logic [W-1:0] model_next(input logic [3:0] ic, input logic c,
                                              input logic [W-1:0] p, input logic [W-1:0] k,
                                              input logic [W-1:0] m, input logic [W-1:0] cur);
    int code;
    code = int'(ic);
    if (code == 7) return c ? k : p;
    if (code == 8) return k;
    if (code == 9) return m;
    if ((code >= 1 && code <= 6) || code == 10 || code == 11) return p;
    return cur;
  endfunction

  logic [W-1:0] model_pc;
  logic         model_ok;
  initial model_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_pc = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      model_pc = model_next(icode, Cnd, valP, valC, valM, model_pc);
    end
    #1;
    if (model_ok) check("model", PC_u, model_pc);
  end

  task automatic apply(input string name, input logic r, input logic [3:0] ic, input logic c,
                       input logic [W-1:0] p, input logic [W-1:0] k, input logic [W-1:0] m,
                       input logic [W-1:0] exp);
    @(negedge clk);
    rst_n = r; icode = ic; Cnd = c; valP = p; valC = k; valM = m;
    @(posedge clk);
    #2;
    check(name, PC_u, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0; icode = 4'h3; Cnd = 1'b0; valP = 64'd5; valC = '0; valM = '0;

    apply("reset_a",      1'b0, 4'h3, 1'b0, 64'd5,   64'd0,  64'd0,  64'd0);
    apply("reset_b",      1'b0, 4'h3, 1'b0, 64'd5,   64'd0,  64'd0,  64'd0);
    apply("release",      1'b1, 4'h3, 1'b0, 64'd5,   64'd0,  64'd0,  64'd5);
    apply("jxx_not_tkn",  1'b1, 4'h7, 1'b0, 64'd4,   64'd8,  64'd0,  64'd4);
    apply("jxx_taken",    1'b1, 4'h7, 1'b1, 64'd4,   64'd8,  64'd0,  64'd8);
    apply("call",         1'b1, 4'h8, 1'b0, 64'd1,   64'd2,  64'd3,  64'd2);
    apply("ret",          1'b1, 4'h9, 1'b1, 64'd3,   64'd6,  64'd9,  64'd9);
    apply("irmovq",       1'b1, 4'h3, 1'b0, 64'd10,  64'd20, 64'd30, 64'd10);
    apply("mrmovq",       1'b1, 4'h5, 1'b0, 64'd5,   64'd10, 64'd15, 64'd5);
    apply("cmov",         1'b1, 4'h2, 1'b1, 64'd7,   64'd99, 64'd0,  64'd7);
    apply("halt_hold",    1'b1, 4'h0, 1'b0, 64'd100, 64'd0,  64'd0,  64'd7);
    apply("invalid_hold", 1'b1, 4'hE, 1'b0, 64'd200, 64'd0,  64'd0,  64'd7);
    apply("call_max",     1'b1, 4'h8, 1'b0, 64'd0,   64'hFFFF_FFFF_FFFF_FFF0, 64'd0,
          64'hFFFF_FFFF_FFFF_FFF0);
    apply("reset_mid",    1'b0, 4'h8, 1'b0, 64'd0,   64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0);

    // Sweep every icode with both Cnd values and distinct sources; model checks each edge.
    apply("seed",         1'b1, 4'h1, 1'b0, 64'h1234, 64'd0, 64'd0, 64'h1234);
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        icode = 4'(i);
        Cnd   = 1'(c);
        valP  = 64'h1000 + 64'(i * 2 + c);
        valC  = 64'hC000_0000_0000_0000 | 64'(i * 2 + c);
        valM  = 64'hA5A5_0000_0000_0000 | 64'(i * 2 + c);
      end
    end
    apply("popq",         1'b1, 4'hB, 1'b1, 64'h55,  64'h66, 64'h77, 64'h55);
    apply("hold_invalid", 1'b1, 4'hF, 1'b1, 64'h88,  64'h99, 64'hAA, 64'h55);
    apply("pushq",        1'b1, 4'hA, 1'b0, 64'hBB,  64'hCC, 64'hDD, 64'hBB);
    apply("ret_upper",    1'b1, 4'h9, 1'b0, 64'h1,   64'h2,  64'h8000_0000_0000_0001,
          64'h8000_0000_0000_0001);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_update.md
Name: pc_update

Overview:
- Next-PC selection and PC register for the Y86-64 sequential (SEQ) processor.
- Sits after the memory stage.
- Selects the next program counter from valP (fall-through), valC (branch/call target) or valM (return address popped from stack) based on icode and Cnd.
- Registers the selection on the rising clock edge; PC_u feeds the fetch stage.

Parameters:
- W, 64, PC and datapath width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- icode  input  4  instruction code of the current instruction.
- Cnd  input  1  condition flag from execute stage; 1 = branch condition true.
- valP  input  W  address of the sequentially next instruction.
- valC  input  W  constant word from the instruction (jump/call destination).
- valM  input  W  value read from memory (return address for ret).
- PC_u  output  W  registered program counter for the next fetch.

Behaviour:
- Single W-bit register drives PC_u. No combinational path from inputs to PC_u.
- Reset: on a rising clk edge with rst_n=0, PC_u <= 0. Reset has priority over all other inputs. Reset mid-operation discards the pending selection. PC_u stays 0 while rst_n=0.
- Otherwise, on each rising clk edge PC_u <= next_pc, selected by icode:
  - 4'h7 jXX: Cnd=1 -> valC; Cnd=0 -> valP.
  - 4'h8 call: valC, Cnd ignored.
  - 4'h9 ret: valM, Cnd ignored.
  - 4'h0 halt: PC_u holds its current value (processor frozen).
  - 4'h1–4'h6, 4'hA, 4'hB (nop, cmovXX, irmovq, rmmovq, mrmovq, OPq, pushq, popq): valP. For cmovXX, Cnd does not affect the PC.
  - 4'hC–4'hF (invalid codes): PC_u holds its current value.
- Latency: one clock. Inputs must be stable around the rising edge; a change at the falling edge is reflected in PC_u at the next rising edge.
- Widths: straight W-bit copies. No arithmetic and no wrap handling; valP increment is done upstream.
- X/Z on icode is not required to be handled. Treat any unlisted value as hold.

Test Plan:
Clock period 10; drive inputs at falling edges; check PC_u after the following rising edge.
1. rst_n=0 for 2 edges with valP=5, icode=3 -> PC_u=0. Release rst_n; next edge -> PC_u=5.
2. icode=7, Cnd=0, valP=4, valC=8, valM=0 -> PC_u=4. Then Cnd=1, same values -> PC_u=8.
3. icode=8, Cnd=0, valP=1, valC=2, valM=3 -> PC_u=2 (call ignores Cnd). Then icode=9, Cnd=1, valP=3, valC=6, valM=9 -> PC_u=9.
4. icode=3, Cnd=0, valP=10, valC=20, valM=30 -> PC_u=10. Then icode=5, valP=5, valC=10, valM=15 -> PC_u=5. Then icode=2 (cmov), Cnd=1, valP=7, valC=99 -> PC_u=7.
5. PC_u=7, then icode=0, valP=100 -> PC_u stays 7. Then icode=4'hE, valP=200 -> stays 7.
6. Reset mid-stream: icode=8, valC=64'hFFFF_FFFF_FFFF_FFF0 -> PC_u=that value. Then rst_n=0 with icode=8 -> PC_u=0 at that edge.
